keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 100000, clk cycles each column is driven (legal minimum 4).
REQ-002 SHALL have parameter DB_CYCLES, default 20000, consecutive stable cycles required for press and for release.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  system clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port row  in  4  raw keypad rows, active-low, asynchronous to clk.
REQ-007 SHALL have port col  out  4  column drive, active-low, exactly one bit low at all times.
REQ-008 SHALL have port key_code  out  4  code of the reported key.
REQ-009 SHALL have port key_valid  out  1  key_code holds an unacknowledged key.
REQ-010 SHALL have port key_ack  in  1  consumer acknowledge, sampled while key_valid=1.
REQ-011 SHALL have port key_held  out  1  debounced key currently held down.

Function
REQ-012 SHALL pass row through a 2-flop synchronizer (reset value 4'b1111); all decisions use the synchronized value rs.
REQ-013 SHALL implement an FSM with states SCAN, DEBOUNCE, REPORT and RELEASE.
REQ-014 In SCAN, SHALL hold each column for SCAN_CYCLES cycles, sample rs on the last cycle, then advance col 1110->1101->1011->0111->1110.
REQ-015 In SCAN, if the sampled rs != 4'b1111, SHALL capture the column index c and the lowest-numbered low row r, freeze col, clear the counter and enter DEBOUNCE.
REQ-016 In DEBOUNCE, SHALL count consecutive cycles with rs[r]=0; any cycle with rs[r]=1 returns to SCAN on the same column with the counter cleared.
REQ-017 After DB_CYCLES consecutive matches, SHALL latch key_code, set key_valid=1 and key_held=1 on the next edge, and enter REPORT.
REQ-018 key_code map (row r, col c) SHALL be: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D.
REQ-019 In REPORT, key_valid and key_code SHALL stay stable until key_ack=1 is sampled; key_valid SHALL clear on the following edge, then the FSM enters RELEASE.
REQ-020 key_ack while key_valid=0 SHALL be ignored.
REQ-021 In RELEASE, SHALL keep col frozen and count consecutive cycles with rs[r]=1; any rs[r]=0 restarts the count.
REQ-022 After DB_CYCLES release cycles, SHALL clear key_held and return to SCAN at column (c+1) mod 4.
REQ-023 A key released during REPORT SHALL still be held in key_valid; key_held SHALL clear only via RELEASE.
REQ-024 No new key SHALL be detected while in DEBOUNCE, REPORT or RELEASE; other keys are neither queued nor lost-flagged.
REQ-025 When multiple rows are low in one column, the lowest row index SHALL win; across columns, the first found in scan order wins.
REQ-026 Counters SHALL be sized to ceil(log2(max(SCAN_CYCLES, DB_CYCLES)+1)) bits and SHALL never wrap within a state.

Reset
REQ-027 reset=0 SHALL immediately force col=4'b1110, key_code=0, key_valid=0, key_held=0, state SCAN, all counters 0, and sync flops to 4'b1111.
REQ-028 Reset asserted in any state SHALL abandon that state with no pending key; operation resumes at column 0 on the first edge after reset=1.

Verification (SCAN_CYCLES=4, DB_CYCLES=8)
REQ-029 Reset check: reset=0 mid-scan -> col=1110, key_valid=0, key_code=0, key_held=0 without a clock edge.
REQ-030 Press check: hold row1 low whenever col=1011 -> key_valid=1, key_code=6, key_held=1; pulse key_ack -> key_valid=0 the next cycle; release row -> key_held=0 after 8 high cycles.
REQ-031 Bounce check: toggle row0 every 3 cycles for 30 cycles on col 0, then hold it low -> no key_valid during the bounce and exactly one key_valid with key_code=1.
REQ-032 Pending check: press and release '1' without ack, then press '9' -> key_valid stays 1 with code 1; after key_ack, '9' is reported next.
REQ-033 Priority check: rows 0 and 2 low on col 1 -> key_code=2.
REQ-034 Mid-operation reset: reset=0 during DEBOUNCE -> no key_valid; after reset=1 with the key still held, a full debounce is required before key_valid.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, debounces the
// first key found, reports it with a valid/ack handshake and debounces its release.
module keypad_scan #(
  parameter int SCAN_CYCLES = 100000,
  parameter int DB_CYCLES   = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic [1:0] o_dbg_state
);

  localparam int MAX_CYCLES = (SCAN_CYCLES > DB_CYCLES) ? SCAN_CYCLES : DB_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_REPORT,
    ST_RELEASE
  } state_t;

  // Handshake: key_valid=1 means key_code holds an unconsumed key; the key is
  // consumed on the edge where key_ack=1 is sampled, and key_ack is ignored otherwise.

  state_t        r_state;
  logic [3:0]    r_sync1;
  logic [3:0]    r_rs;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_col_idx;
  logic [1:0]    r_row_idx;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_held;

  state_t        w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [1:0]    w_col_idx_nx;
  logic [1:0]    w_row_idx_nx;
  logic [3:0]    w_key_code_nx;
  logic          w_key_valid_nx;
  logic          w_key_held_nx;
  logic [1:0]    w_low_row;
  logic          w_row_level;

  function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] v;
    case ({r, c})
      4'h0: v = 4'h1;  4'h1: v = 4'h2;  4'h2: v = 4'h3;  4'h3: v = 4'hA;
      4'h4: v = 4'h4;  4'h5: v = 4'h5;  4'h6: v = 4'h6;  4'h7: v = 4'hB;
      4'h8: v = 4'h7;  4'h9: v = 4'h8;  4'hA: v = 4'h9;  4'hB: v = 4'hC;
      4'hC: v = 4'hE;  4'hD: v = 4'h0;  4'hE: v = 4'hF;  4'hF: v = 4'hD;
      default: v = 4'h0;
    endcase
    return v;
  endfunction

  // Lowest-numbered low row wins when several rows are pulled down together.
  always_comb begin
    w_low_row = 2'd3;
    if (!r_rs[0])      w_low_row = 2'd0;
    else if (!r_rs[1]) w_low_row = 2'd1;
    else if (!r_rs[2]) w_low_row = 2'd2;
  end

  assign w_row_level = r_rs[r_row_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1     <= 4'hF;
      r_rs        <= 4'hF;
      r_state     <= ST_SCAN;
      r_cnt       <= '0;
      r_col_idx   <= 2'd0;
      r_row_idx   <= 2'd0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_sync1     <= row;
      r_rs        <= r_sync1;
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_col_idx   <= w_col_idx_nx;
      r_row_idx   <= w_row_idx_nx;
      r_key_code  <= w_key_code_nx;
      r_key_valid <= w_key_valid_nx;
      r_key_held  <= w_key_held_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_col_idx_nx   = r_col_idx;
    w_row_idx_nx   = r_row_idx;
    w_key_code_nx  = r_key_code;
    w_key_valid_nx = r_key_valid;
    w_key_held_nx  = r_key_held;
    case (r_state)
      ST_SCAN: begin
        if (r_cnt == SCAN_LAST) begin
          w_cnt_nx = '0;
          if (r_rs != 4'hF) begin
            w_row_idx_nx = w_low_row;
            w_state_nx   = ST_DEBOUNCE;
          end else begin
            w_col_idx_nx = r_col_idx + 2'd1;
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_DEBOUNCE: begin
        // A single bounce back to high abandons the press and rescans this column.
        if (w_row_level) begin
          w_cnt_nx   = '0;
          w_state_nx = ST_SCAN;
        end else if (r_cnt == DB_LAST) begin
          w_cnt_nx       = '0;
          w_key_code_nx  = code_of(r_row_idx, r_col_idx);
          w_key_valid_nx = 1'b1;
          w_key_held_nx  = 1'b1;
          w_state_nx     = ST_REPORT;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_REPORT: begin
        if (key_ack) begin
          w_key_valid_nx = 1'b0;
          w_cnt_nx       = '0;
          w_state_nx     = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!w_row_level) begin
          w_cnt_nx = '0;
        end else if (r_cnt == DB_LAST) begin
          w_cnt_nx      = '0;
          w_key_held_nx = 1'b0;
          w_col_idx_nx  = r_col_idx + 2'd1;
          w_state_nx    = ST_SCAN;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: w_state_nx = ST_SCAN;
    endcase
  end

  assign col         = ~(4'b0001 << r_col_idx);
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_held    = r_key_held;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a simulated key matrix, a deadline/run-length reference
// model compared every cycle, directed scenarios with literal expectations, random episodes.
module tb_keypad_scan;

  localparam int SCAN = 4;
  localparam int DB   = 8;
  localparam int M_SCAN = 0, M_DEB = 1, M_REP = 2, M_REL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_ack = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_CYCLES(SCAN), .DB_CYCLES(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_held    (key_held),
    .o_dbg_state (dbg_state)
  );

  // Physical matrix: a pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  // ---------------- reference model ----------------
  int         m_mode, m_col, m_row, m_run, m_cycle, m_deadline;
  logic [3:0] m_code, m_s1, m_s2, row_lat;
  logic       m_valid, m_held;

  always @(negedge clk) row_lat = row;

  task automatic model_reset();
    m_mode = M_SCAN; m_col = 0; m_row = 0; m_run = 0;
    m_cycle = 0; m_deadline = SCAN - 1;
    m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
    m_s1 = 4'hF; m_s2 = 4'hF;
  endtask

  always @(posedge clk or negedge reset) begin : model
    logic [3:0] rs;
    if (!reset) begin
      model_reset();
    end else begin
      rs = m_s2;
      case (m_mode)
        M_SCAN: if (m_cycle == m_deadline) begin
          if (rs != 4'hF) begin
            for (int r = 3; r >= 0; r--) if (!rs[r]) m_row = r;
            m_run  = 0;
            m_mode = M_DEB;
          end else begin
            m_col = (m_col + 1) % 4;
            m_deadline = m_cycle + SCAN;
          end
        end
        M_DEB: if (!rs[m_row]) begin
          m_run++;
          if (m_run == DB) begin
            m_code = key_map[m_row*4 + m_col];
            m_valid = 1'b1; m_held = 1'b1;
            m_mode = M_REP;
          end
        end else begin
          m_mode = M_SCAN;
          m_deadline = m_cycle + SCAN;
        end
        M_REP: if (key_ack) begin
          m_valid = 1'b0; m_run = 0; m_mode = M_REL;
        end
        M_REL: if (rs[m_row]) begin
          m_run++;
          if (m_run == DB) begin
            m_held = 1'b0;
            m_col = (m_col + 1) % 4;
            m_mode = M_SCAN;
            m_deadline = m_cycle + SCAN;
          end
        end else begin
          m_run = 0;
        end
        default: m_mode = M_SCAN;
      endcase
      m_s2 = m_s1;
      m_s1 = row_lat;
      m_cycle++;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_col", col, 4'hF ^ (4'b0001 << m_col));
      check("model_key_code", key_code, m_code);
      check("model_key_valid", {3'b0, key_valid}, {3'b0, m_valid});
      check("model_key_held", {3'b0, key_held}, {3'b0, m_held});
    end
  end

  int   rise_cnt = 0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (key_valid === 1'b1 && prev_valid !== 1'b1) rise_cnt++;
    prev_valid = key_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  // which: 0 = key_valid, 1 = key_held; n = posedges until the level is seen.
  task automatic wait_sig(input int which, input logic level, input int bound,
                          output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < bound && !ok) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (((which == 0) ? key_valid : key_held) === level) ok = 1'b1;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic expect_sig(input string name, input int which, input logic level, input int bound);
    int n; bit ok;
    wait_sig(which, level, bound, n, ok);
    check_int(name, int'(ok), 1);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(posedge clk);
    #2;
    key_ack = 1'b0;
    @(negedge clk);
    check("ack_clears_valid", {3'b0, key_valid}, 4'h0);
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_now(input string tag);
    #1 reset = 1'b0;
    #1;
    check({tag, "_col"}, col, 4'b1110);
    check({tag, "_valid"}, {3'b0, key_valid}, 4'h0);
    check({tag, "_code"}, key_code, 4'h0);
    check({tag, "_held"}, {3'b0, key_held}, 4'h0);
  endtask

  task automatic rand_cycle();
    key_ack = ($urandom_range(0, 5) == 0);
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n; bit ok; int base;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    tick(2);
    reset = 1'b1;

    // Asynchronous reset in the middle of scanning.
    tick(6);
    check_reset_now("rst_midscan");
    tick(2);
    reset = 1'b1;

    // Press '6' (row 1, column 2), acknowledge, release.
    keys = 16'h0040;
    expect_sig("press6_valid", 0, 1'b1, 200);
    check("press6_code", key_code, 4'h6);
    check("press6_held", {3'b0, key_held}, 4'h1);
    ack_pulse();
    keys = '0;
    wait_sig(1, 1'b0, 100, n, ok);
    check_int("release6_cycles", n, 10);

    // Bouncing '1' on column 0, then held low.
    do_reset();
    base = rise_cnt;
    for (int i = 0; i < 30; i++) begin
      keys[0] = ((i / 3) % 2 == 0);
      tick(1);
    end
    check_int("bounce_no_valid", rise_cnt - base, 0);
    keys[0] = 1'b1;
    expect_sig("bounce_valid", 0, 1'b1, 200);
    check("bounce_code", key_code, 4'h1);
    tick(20);
    check_int("bounce_one_report", rise_cnt - base, 1);
    ack_pulse();
    keys = '0;
    expect_sig("bounce_release", 1, 1'b0, 100);

    // Pending key: '1' released without ack, then '9' pressed.
    keys = 16'h0001;
    expect_sig("pend1_valid", 0, 1'b1, 200);
    keys = '0;
    tick(20);
    keys = 16'h0400;
    tick(40);
    check("pend_still_valid", {3'b0, key_valid}, 4'h1);
    check("pend_still_code1", key_code, 4'h1);
    ack_pulse();
    expect_sig("pend9_valid", 0, 1'b1, 200);
    check("pend9_code", key_code, 4'h9);
    check_reset_now("rst_reported");
    keys = '0;
    tick(2);
    reset = 1'b1;

    // Rows 0 and 2 both low on column 1: row 0 wins.
    keys = 16'h0202;
    expect_sig("prio_valid", 0, 1'b1, 200);
    check("prio_code", key_code, 4'h2);
    ack_pulse();
    keys = '0;
    expect_sig("prio_release", 1, 1'b0, 100);

    // Reset while debouncing '5'; a full debounce is needed afterwards.
    do_reset();
    keys = 16'h0020;
    base = rise_cnt;
    n = 0;
    while (m_mode != M_DEB && n < 100) begin
      tick(1);
      n++;
    end
    check_int("midrst_reached_debounce", int'(m_mode == M_DEB), 1);
    tick(3);
    reset = 1'b0;
    tick(3);
    check_int("midrst_no_valid", rise_cnt - base, 0);
    reset = 1'b1;
    wait_sig(0, 1'b1, 100, n, ok);
    check_int("midrst_cycles_to_valid", n, 16);
    check("midrst_code", key_code, 4'h5);
    ack_pulse();
    keys = '0;
    expect_sig("midrst_release", 1, 1'b0, 100);

    // Random episodes: bounces, one or two keys, random ack (also while idle).
    base = rise_cnt;
    for (int ep = 0; ep < 14; ep++) begin
      int k1; int nb; int len;
      k1 = $urandom_range(0, 15);
      keys = '0;
      keys[k1] = 1'b1;
      if ($urandom_range(0, 2) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      nb = $urandom_range(0, 4);
      for (int b = 0; b < nb; b++) begin
        keys[k1] = ~keys[k1];
        len = $urandom_range(1, 3);
        repeat (len) rand_cycle();
      end
      keys[k1] = 1'b1;
      len = $urandom_range(20, 90);
      repeat (len) rand_cycle();
      keys = '0;
      len = $urandom_range(10, 60);
      repeat (len) rand_cycle();
    end
    key_ack = 1'b0;
    n_tests++;
    if (rise_cnt - base <= 0) begin
      n_fail++;
      $display("FAIL rand_reports: got %0d reports expected at least 1", rise_cnt - base);
    end
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
